// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader
// Accepts decoded instruction fields over a valid/ready handshake, packs them
// into 32-bit instruction words and writes them into an instruction memory,
// starting at a base address given with the start pulse.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   start, base       begin a load session at address base (accepted in IDLE only)
//   in_valid/in_ready field handshake; in_ready is high only in LOAD
//   in_op, in_cond, in_rd, in_rn, in_imm, in_last
//                     instruction fields; in_last ends the session
//   imem_we/addr/wdata registered instruction-memory write port (latency 1)
//   busy, done        session in progress / one-cycle end-of-session pulse
//   err_illegal       sticky: an illegal opcode (1101..1111) was dropped
//   err_full          sticky: session ended because DEPTH words were written
//   state             current FSM state (0 IDLE, 1 LOAD, 2 DONE), for observation
//
// Handshake: a transfer happens on a rising edge where in_valid and in_ready
// are both 1; the source holds its fields stable until that edge, and in_ready
// does not depend on in_valid.
module instr_encoder_loader #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic              in_cond,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rn,
  input  logic [16:0]       in_imm,
  input  logic              in_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err_illegal,
  output logic              err_full,
  output logic [1:0]        state
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Count value just before the DEPTH-th legal write.
  localparam logic [ADDR_W:0] LAST_CNT = DEPTH[ADDR_W:0] - 1'b1;

  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W:0]   count;

  logic        xfer;
  logic        legal;
  logic        keep_imm;
  logic        keep_cond;
  logic        hit_full;
  logic [31:0] enc;

  assign in_ready = (state == LOAD);
  assign busy     = (state == LOAD);
  assign done     = (state == DONE);

  always_comb begin
    xfer      = in_valid && in_ready;
    legal     = (in_op <= 4'd12);
    // Only MOV, ADD, B and BNQ carry an immediate; only BNQ is conditional.
    keep_imm  = (in_op == 4'd0) || (in_op == 4'd2) || (in_op == 4'd4) || (in_op == 4'd5);
    keep_cond = (in_op == 4'd5);
    enc       = {in_op, in_cond & keep_cond, in_rd, in_rn, keep_imm ? in_imm : 17'd0};
    hit_full  = xfer && legal && (count == LAST_CNT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= '0;
      count       <= '0;
      imem_we     <= 1'b0;
      imem_addr   <= '0;
      imem_wdata  <= '0;
      err_illegal <= 1'b0;
      err_full    <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state       <= LOAD;
            ptr         <= base;
            count       <= '0;
            err_illegal <= 1'b0;
            err_full    <= 1'b0;
          end
        end
        LOAD: begin
          if (xfer) begin
            if (legal) begin
              imem_we    <= 1'b1;
              imem_addr  <= ptr;
              imem_wdata <= enc;
              ptr        <= ptr + 1'b1;  // wraps modulo DEPTH
              count      <= count + 1'b1;
            end else begin
              err_illegal <= 1'b1;
            end
            // Full and in_last together still end the session only once.
            if (hit_full) err_full <= 1'b1;
            if (hit_full || in_last) state <= DONE;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
module tb_instr_encoder_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, start4;
  logic [7:0]  base;
  logic [1:0]  base4;
  logic        in_valid, in_valid4;
  logic [3:0]  in_op;
  logic        in_cond;
  logic [4:0]  in_rd, in_rn;
  logic [16:0] in_imm;
  logic        in_last;

  logic        in_ready, imem_we, busy, done, err_illegal, err_full;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic [1:0]  state;

  logic        in_ready4, imem_we4, busy4, done4, err_illegal4, err_full4;
  logic [1:0]  imem_addr4;
  logic [31:0] imem_wdata4;
  logic [1:0]  state4;

  int n_checks = 0;
  int n_fails  = 0;

  logic [31:0] exp_q[$];
  logic [7:0]  exp_addr;
  logic [31:0] exp_w;
  logic        prev_xfer;

  instr_encoder_loader dut (
    .clk(clk), .rst(rst), .start(start), .base(base),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_cond(in_cond), .in_rd(in_rd), .in_rn(in_rn),
    .in_imm(in_imm), .in_last(in_last),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .busy(busy), .done(done), .err_illegal(err_illegal), .err_full(err_full),
    .state(state)
  );

  instr_encoder_loader #(.DEPTH(4), .ADDR_W(2)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .base(base4),
    .in_valid(in_valid4), .in_ready(in_ready4),
    .in_op(in_op), .in_cond(in_cond), .in_rd(in_rd), .in_rn(in_rn),
    .in_imm(in_imm), .in_last(in_last),
    .imem_we(imem_we4), .imem_addr(imem_addr4), .imem_wdata(imem_wdata4),
    .busy(busy4), .done(done4), .err_illegal(err_illegal4), .err_full(err_full4),
    .state(state4)
  );

  // clock
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic cond, input logic [4:0] rd,
                       input logic [4:0] rn, input logic [16:0] imm, input logic last);
    in_op = op; in_cond = cond; in_rd = rd; in_rn = rn; in_imm = imm; in_last = last;
  endtask

  // Reference packing from the instruction format.
  function automatic logic [31:0] ref_word(input logic [3:0] op, input logic cond,
                                           input logic [4:0] rd, input logic [4:0] rn,
                                           input logic [16:0] imm);
    logic [16:0] i;
    logic        c;
    i = (op == 4'd0 || op == 4'd2 || op == 4'd4 || op == 4'd5) ? imm : 17'd0;
    c = (op == 4'd5) ? cond : 1'b0;
    return {op, c, rd, rn, i};
  endfunction

  initial begin
    rst = 1'b1; start = 0; start4 = 0; base = 0; base4 = 0;
    in_valid = 0; in_valid4 = 0;
    drive(4'd0, 0, 0, 0, 0, 0);
    tick(); tick();
    check("rst_state", 32'(state), 0);
    check("rst_ready", 32'(in_ready), 0);
    check("rst_we", 32'(imem_we), 0);
    check("rst_addr", 32'(imem_addr), 0);
    check("rst_wdata", imem_wdata, 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_errs", {30'd0, err_illegal, err_full}, 0);
    rst = 1'b0;
    tick();
    check("idle_ready", 32'(in_ready), 0);

    // MOV with cond forced off
    start = 1; base = 8'h10; tick(); start = 0;
    check("load_busy", 32'(busy), 1);
    check("load_ready", 32'(in_ready), 1);
    in_valid = 1; drive(4'd0, 1, 5'd3, 5'd0, 17'h1ABCD, 0);
    tick(); in_valid = 0;
    check("mov_we", 32'(imem_we), 1);
    check("mov_addr", 32'(imem_addr), 32'h10);
    check("mov_wdata", imem_wdata, 32'h00C1ABCD);
    tick();
    check("mov_we_once", 32'(imem_we), 0);

    // BNQ keeps cond and imm, last ends the session
    in_valid = 1; drive(4'd5, 1, 5'd0, 5'd0, 17'h5, 1);
    tick(); in_valid = 0; in_last = 0;
    check("bnq_we", 32'(imem_we), 1);
    check("bnq_addr", 32'(imem_addr), 32'h11);
    check("bnq_wdata", imem_wdata, 32'h58000005);
    check("bnq_done", 32'(done), 1);
    check("bnq_busy", 32'(busy), 0);
    check("bnq_ready", 32'(in_ready), 0);
    tick();
    check("bnq_done_pulse", 32'(done), 0);
    check("bnq_idle", 32'(state), 0);

    // illegal opcode dropped; start during LOAD ignored
    start = 1; base = 8'h20; tick(); start = 0;
    in_valid = 1; drive(4'he, 0, 5'd2, 5'd2, 17'h3, 0);
    tick();
    check("ill_we", 32'(imem_we), 0);
    check("ill_flag", 32'(err_illegal), 1);
    start = 1; base = 8'h30;
    drive(4'd1, 0, 5'd1, 5'd0, 17'h1FFFF, 0);
    tick(); start = 0;
    check("inc_we", 32'(imem_we), 1);
    check("inc_addr", 32'(imem_addr), 32'h20);
    check("inc_wdata", imem_wdata, 32'h10400000);
    check("inc_busy", 32'(busy), 1);
    drive(4'hf, 0, 5'd0, 5'd0, 17'h0, 1);
    tick(); in_valid = 0; in_last = 0;
    check("ill_last_we", 32'(imem_we), 0);
    check("ill_last_done", 32'(done), 1);
    check("ill_sticky", 32'(err_illegal), 1);
    tick();
    check("ill_hold_idle", 32'(err_illegal), 1);
    start = 1; base = 8'h40; tick(); start = 0;
    check("ill_cleared", 32'(err_illegal), 0);

    // reset in the same cycle as a transfer cancels the write
    in_valid = 1; rst = 1; drive(4'd0, 0, 5'd2, 5'd0, 17'h7, 0);
    tick(); in_valid = 0; rst = 0;
    check("rstx_we", 32'(imem_we), 0);
    check("rstx_addr", 32'(imem_addr), 0);
    check("rstx_busy", 32'(busy), 0);
    check("rstx_ready", 32'(in_ready), 0);
    tick();
    check("rstx_we2", 32'(imem_we), 0);
    start = 1; base = 8'h50; tick(); start = 0;
    in_valid = 1; drive(4'd2, 0, 5'd4, 5'd5, 17'h12, 0);
    tick(); in_valid = 0;
    check("clean_addr", 32'(imem_addr), 32'h50);
    check("clean_wdata", imem_wdata, 32'h210A0012);
    check("clean_we", 32'(imem_we), 1);

    // random in_valid with address wrap, then finish the session
    in_last = 0; in_valid = 1; drive(4'd0, 0, 0, 0, 0, 1);
    tick(); in_valid = 0; in_last = 0; tick();
    start = 1; base = 8'hFE; tick(); start = 0;
    exp_addr = 8'hFE; prev_xfer = 0;
    for (int i = 0; i < 14; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      drive(4'($urandom_range(0, 12)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
            5'($urandom_range(0, 31)), 17'($urandom_range(0, 131071)), 0);
      if (in_valid) exp_q.push_back(ref_word(in_op, in_cond, in_rd, in_rn, in_imm));
      prev_xfer = in_valid;
      tick();
      check("rnd_we", 32'(imem_we), 32'(prev_xfer));
      if (prev_xfer) begin
        exp_w = exp_q.pop_front();
        check("rnd_addr", 32'(imem_addr), 32'(exp_addr));
        check("rnd_wdata", imem_wdata, exp_w);
        exp_addr = exp_addr + 8'd1;
      end
    end
    in_valid = 1; drive(4'd3, 1, 5'd9, 5'd9, 17'h1, 1);
    tick(); in_valid = 0; in_last = 0;
    check("rnd_last_addr", 32'(imem_addr), 32'(exp_addr));
    check("rnd_last_wdata", imem_wdata, 32'h32520000);
    check("rnd_done", 32'(done), 1);
    tick();

    // DEPTH=4 fill from base 3
    start4 = 1; base4 = 2'd3; tick(); start4 = 0;
    in_valid4 = 1;
    for (int i = 0; i < 4; i++) begin
      drive(4'd2, 0, 5'(i), 5'd0, 17'(i + 1), 0);
      tick();
      check("full_we", 32'(imem_we4), 1);
      check("full_addr", 32'(imem_addr4), 32'((3 + i) % 4));
      check("full_wdata", imem_wdata4, {4'd2, 1'b0, 5'(i), 5'd0, 17'(i + 1)});
    end
    check("full_ready", 32'(in_ready4), 0);
    check("full_flag", 32'(err_full4), 1);
    check("full_done", 32'(done4), 1);
    tick();
    check("full_no_we", 32'(imem_we4), 0);
    check("full_done_pulse", 32'(done4), 0);
    check("full_hold", 32'(err_full4), 1);
    check("full_ready2", 32'(in_ready4), 0);
    in_valid4 = 0;

    // DEPTH=4, in_last on the 4th write ends the session once
    start4 = 1; base4 = 2'd0; tick(); start4 = 0;
    check("full2_cleared", 32'(err_full4), 0);
    in_valid4 = 1;
    for (int i = 0; i < 4; i++) begin
      drive(4'd0, 0, 5'd1, 5'd0, 17'h0, (i == 3) ? 1'b1 : 1'b0);
      tick();
    end
    in_valid4 = 0; in_last = 0;
    check("full2_addr", 32'(imem_addr4), 3);
    check("full2_flag", 32'(err_full4), 1);
    check("full2_done", 32'(done4), 1);
    tick();
    check("full2_done_once", 32'(done4), 0);
    check("full2_idle", 32'(state4), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
